// File: rtl/double_unit_arbiter.sv
// Round-robin front end that time-shares one fixed-latency pipelined unit between
// N_REQ requesters, tagging each issue so its result lands in the owner's holding register.
module double_unit_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 1,
    parameter int WIDTH   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ*WIDTH-1:0] rsp_z,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       unit_a,
    output logic                   unit_valid,
    input  logic [WIDTH-1:0]       unit_z
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            busy_q;
    logic [N_REQ-1:0]            eligible;
    logic [N_REQ-1:0]            grant_oh;
    logic [N_REQ-1:0]            rsp_valid_q;
    logic [N_REQ-1:0]            rsp_hs;
    logic [N_REQ-1:0][WIDTH-1:0] rsp_z_q;
    logic                        grant_found;
    logic [IDX_W-1:0]            grant_idx;
    logic [IDX_W-1:0]            scan_idx;
    logic [IDX_W-1:0]            ptr_q;
    logic [IDX_W-1:0]            ptr_d;
    logic [WIDTH-1:0]            unit_a_q;
    logic                        unit_valid_q;
    logic                        cap_valid;
    logic [IDX_W-1:0]            cap_idx;

    // Tag stage 0 is loaded together with unit_a, so the unit's registered result
    // lines up with stage LATENCY one cycle further on.
    logic [LATENCY:0]            tag_valid_q;
    logic [LATENCY:0][IDX_W-1:0] tag_idx_q;

    assign eligible = req_valid & ~busy_q;
    assign rsp_hs   = rsp_valid_q & rsp_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int off = 0; off < N_REQ; off++) begin
            scan_idx = IDX_W'((int'(ptr_q) + off) % N_REQ);
            if (!grant_found && eligible[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_found) begin
            ptr_d = IDX_W'((int'(grant_idx) + 1) % N_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q          <= '0;
            unit_a_q       <= '0;
            unit_valid_q   <= 1'b0;
            tag_valid_q[0] <= 1'b0;
            tag_idx_q[0]   <= '0;
        end else begin
            ptr_q          <= ptr_d;
            unit_valid_q   <= grant_found;
            tag_valid_q[0] <= grant_found;
            tag_idx_q[0]   <= grant_idx;
            if (grant_found) begin
                unit_a_q <= req_a[grant_idx*WIDTH +: WIDTH];
            end
        end
    end

    generate
        for (genvar gi = 1; gi <= LATENCY; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_valid_q[gi] <= 1'b0;
                    tag_idx_q[gi]   <= '0;
                end else begin
                    tag_valid_q[gi] <= tag_valid_q[gi-1];
                    tag_idx_q[gi]   <= tag_idx_q[gi-1];
                end
            end
        end
    endgenerate

    assign cap_valid = tag_valid_q[LATENCY];
    assign cap_idx   = tag_idx_q[LATENCY];

    // Busy spans accept to result handshake, so a slot is never written while full.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    busy_q[gi]      <= 1'b0;
                    rsp_valid_q[gi] <= 1'b0;
                    rsp_z_q[gi]     <= '0;
                end else begin
                    if (grant_oh[gi]) begin
                        busy_q[gi] <= 1'b1;
                    end else if (rsp_hs[gi]) begin
                        busy_q[gi] <= 1'b0;
                    end
                    if (cap_valid && (cap_idx == IDX_W'(gi))) begin
                        rsp_z_q[gi]     <= unit_z;
                        rsp_valid_q[gi] <= 1'b1;
                    end else if (rsp_hs[gi]) begin
                        rsp_valid_q[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    cap_no_overrun: assert property (@(posedge clk) disable iff (rst)
        cap_valid |-> !rsp_valid_q[cap_idx]);

    assign req_ready  = grant_oh;
    assign rsp_z      = rsp_z_q;
    assign rsp_valid  = rsp_valid_q;
    assign unit_a     = unit_a_q;
    assign unit_valid = unit_valid_q;

endmodule

// File: tb/tb_double_unit_arbiter.sv
// Directed bench: four requesters sharing a behavioural one-cycle double_abs unit.
module tb_double_unit_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] req_a;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [255:0] rsp_z;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [63:0]  unit_a;
    logic         unit_valid;
    logic [63:0]  unit_z;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] a_val   [4];
    logic [63:0] abs_val [4];

    always #5 clk = ~clk;

    // Shared unit: double_abs with one register stage.
    always @(posedge clk) unit_z <= {1'b0, unit_a[62:0]};

    double_unit_arbiter #(.N_REQ(4), .LATENCY(1), .WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .rsp_z      (rsp_z),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .unit_a     (unit_a),
        .unit_valid (unit_valid),
        .unit_z     (unit_z)
    );

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid);
        end
        tests_run++;
        if (unit_valid !== 1'b0 || unit_a !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_unit: got valid=%b a=%h want 0 / 0", unit_valid, unit_a);
        end
        tests_run++;
        if (rsp_z !== 256'h0 || req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_rsp_z_ready: got z=%h ready=%b want 0 / 0000", rsp_z, req_ready);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        req_a[63:0] = 64'h8000000000000001;
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        tests_run++;
        if (unit_valid !== 1'b1 || unit_a !== 64'h8000000000000001 || rsp_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_issue: got uv=%b ua=%h rv=%b want 1 8000000000000001 0000",
                     unit_valid, unit_a, rsp_valid);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 4'b0000 || unit_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_early: got rv=%b uv=%b want 0000 0", rsp_valid, unit_valid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 4'b0001 || rsp_z[63:0] !== 64'h0000000000000001) begin
                tests_failed++;
                $display("FAIL single_hold%0d: got rv=%b z0=%h want 0001 0000000000000001",
                         k, rsp_valid, rsp_z[63:0]);
            end
        end
        rsp_ready = 4'b0001;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_consume: got %b want 0000", rsp_valid);
        end
        $display("[TB] test_single done");
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid = 4'b1111;
                rsp_ready = 4'b1111;
            end
            if (k >= 1) begin
                tests_run++;
                if (unit_valid !== 1'b1 || unit_a !== a_val[(k-1)%4]) begin
                    tests_failed++;
                    $display("FAIL rr_issue%0d: got uv=%b ua=%h want 1 %h",
                             k, unit_valid, unit_a, a_val[(k-1)%4]);
                end
            end
            if (k >= 3) begin
                tests_run++;
                if (rsp_valid !== 4'(1 << ((k+1)%4)) || rsp_z[((k+1)%4)*64 +: 64] !== abs_val[(k+1)%4]) begin
                    tests_failed++;
                    $display("FAIL rr_rsp%0d: got rv=%b z=%h want %b %h", k, rsp_valid,
                             rsp_z[((k+1)%4)*64 +: 64], 4'(1 << ((k+1)%4)), abs_val[(k+1)%4]);
                end
            end
            #1;
            tests_run++;
            if (req_ready !== 4'(1 << (k%4))) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'(1 << (k%4)));
            end
        end
        $display("[TB] test_round_robin done");
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_g [15];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0100, 4'b1000,
                  4'b0001, 4'b0000, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        do_reset();
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            rsp_ready = (k < 10) ? 4'b1101 : 4'b1111;
            if (k >= 1) begin
                tests_run++;
                if (unit_valid !== (|exp_g[k-1])) begin
                    tests_failed++;
                    $display("FAIL bp_uvalid%0d: got %b want %b", k, unit_valid, |exp_g[k-1]);
                end
            end
            if (k >= 4 && k <= 10) begin
                tests_run++;
                if (rsp_valid[1] !== 1'b1 || rsp_z[127:64] !== abs_val[1]) begin
                    tests_failed++;
                    $display("FAIL bp_hold%0d: got rv1=%b z1=%h want 1 %h",
                             k, rsp_valid[1], rsp_z[127:64], abs_val[1]);
                end
            end
            #1;
            tests_run++;
            if (req_ready !== exp_g[k]) begin
                tests_failed++;
                $display("FAIL bp_grant%0d: got %b want %b", k, req_ready, exp_g[k]);
            end
        end
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_reset_midop();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0100;
        rsp_ready = 4'b1111;
        @(negedge clk);
        req_valid = 4'b0000;
        tests_run++;
        if (unit_valid !== 1'b1 || unit_a !== a_val[2]) begin
            tests_failed++;
            $display("FAIL midop_issue: got uv=%b ua=%h want 1 %h", unit_valid, unit_a, a_val[2]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 4'b0000 || unit_valid !== 1'b0 || unit_a !== 64'h0 || rsp_z !== 256'h0) begin
                tests_failed++;
                $display("FAIL midop_quiet%0d: got rv=%b uv=%b ua=%h want 0000 0 0", k,
                         rsp_valid, unit_valid, unit_a);
            end
        end
        req_valid = 4'b1111;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midop_ptr: got %b want 0001", req_ready);
        end
        $display("[TB] test_reset_midop done");
    endtask

    task automatic test_wrap();
        logic [3:0] exp_g [8];
        exp_g = '{4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = 4'b1100;
            rsp_ready = 4'b1111;
            #1;
            tests_run++;
            if (req_ready !== exp_g[k]) begin
                tests_failed++;
                $display("FAIL wrap_grant%0d: got %b want %b", k, req_ready, exp_g[k]);
            end
        end
        $display("[TB] test_wrap done");
    endtask

    task automatic test_drop_on_handshake();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010;
        rsp_ready = 4'b1111;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL drop_first: got %b want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL drop_ignore_ready: got %b want 0000", rsp_valid);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 4'b0010 || rsp_z[127:64] !== abs_val[1]) begin
            tests_failed++;
            $display("FAIL drop_rsp: got rv=%b z1=%h want 0010 %h", rsp_valid, rsp_z[127:64], abs_val[1]);
        end
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL drop_no_spurious: got %b want 0000", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010 || rsp_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL drop_regrant: got ready=%b rv=%b want 0010 0000", req_ready, rsp_valid);
        end
        $display("[TB] test_drop_on_handshake done");
    endtask

    initial begin
        a_val   = '{64'hBFF0000000000000, 64'h4000000000000000, 64'hC008000000000000, 64'h8000000000000005};
        abs_val = '{64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000, 64'h0000000000000005};
        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 4'b0000;
        for (int i = 0; i < 4; i++) req_a[i*64 +: 64] = a_val[i];

        test_reset();
        test_single();
        req_a[63:0] = a_val[0];
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_wrap();
        test_drop_on_handshake();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
